// File: rtl/cell_test_pkg.sv
// Shared definitions for standard-cell sweep benches: sequencer states and
// expected truth tables for common 4-input cells (vector MSB = A, then B, C1, C2).
package cell_test_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } seq_state_t;

   // OAI211: ZN = !((C1|C2)&A&B) -> low only for vectors 13, 14, 15
   localparam logic [15:0] OAI211_TT = 16'h1FFF;
   // AOI211: ZN = !((C1&C2)|A|B) -> high only for vectors 0, 1, 2
   localparam logic [15:0] AOI211_TT = 16'h0007;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that measures how long a stimulus vector has been held.
// Stops at zero; expired is a pure decode of the count.
module settle_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/cell_vector_sequencer.sv
// Walks every input combination of a cell under test, holds each for SETTLE_CYC
// cycles, samples cut_out and compares against EXP_TT, reporting a pass/fail summary.
module cell_vector_sequencer
   import cell_test_pkg::*;
#(
   parameter int                      N_IN       = 4,
   parameter int                      SETTLE_CYC = 10,
   parameter logic [(2**N_IN)-1:0]    EXP_TT     = OAI211_TT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              cut_out,
   output logic [N_IN-1:0]   vec_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     err_cnt,
   output logic              fail_valid,
   output logic [N_IN-1:0]   first_fail_vec
);

   localparam logic [N_IN-1:0] LAST_VEC = '1;
   localparam logic [7:0]      LOAD_VAL = 8'(SETTLE_CYC - 1);

   seq_state_t state, state_nxt;

   logic tmr_load;
   logic tmr_en;
   logic tmr_expired;
   logic accept;
   logic do_abort;
   logic do_sample;
   logic mismatch;
   logic last_vec;

   settle_timer #(.W(8)) u_settle_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .en       (tmr_en),
      .load_val (LOAD_VAL),
      .expired  (tmr_expired)
   );

   assign mismatch = (cut_out != EXP_TT[vec_out]);
   assign last_vec = (vec_out == LAST_VEC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_en    = 1'b0;
      accept    = 1'b0;
      do_abort  = 1'b0;
      do_sample = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               tmr_load  = 1'b1;
               state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               do_abort  = 1'b1;
               state_nxt = ST_IDLE;
            end else if (tmr_expired) begin
               state_nxt = ST_SAMPLE;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_SAMPLE: begin
            // abort takes priority so an in-flight sample is discarded
            if (abort) begin
               do_abort  = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               do_sample = 1'b1;
               if (last_vec) begin
                  state_nxt = ST_DONE;
               end else begin
                  tmr_load  = 1'b1;
                  state_nxt = ST_SETTLE;
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_out        <= '0;
         err_cnt        <= '0;
         pass           <= 1'b0;
         fail_valid     <= 1'b0;
         first_fail_vec <= '0;
      end else if (accept) begin
         vec_out        <= '0;
         err_cnt        <= '0;
         pass           <= 1'b0;
         fail_valid     <= 1'b0;
         first_fail_vec <= '0;
      end else if (do_abort) begin
         vec_out <= '0;
         pass    <= 1'b0;
      end else if (do_sample) begin
         if (mismatch) begin
            err_cnt <= err_cnt + 1'b1;
            if (!fail_valid) begin
               first_fail_vec <= vec_out;
               fail_valid     <= 1'b1;
            end
         end
         // pass is settled on entry to DONE so it is already valid alongside done
         if (last_vec) begin
            pass <= (err_cnt == '0) && !mismatch;
         end else begin
            vec_out <= vec_out + 1'b1;
         end
      end
   end

   assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
   assign done = (state == ST_DONE);

endmodule
